// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: request handshakes and registered writeback-mux operands for the register-file write port
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      stall;
    logic                      alu_valid;
    logic                      alu_ready;
    logic                      alu_is_link;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     alu_pc_plus4;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [1:0]                wb_sel;
    logic [DATA_WIDTH-1:0]     wb_mem_data;
    logic [DATA_WIDTH-1:0]     wb_alu_result;
    logic [DATA_WIDTH-1:0]     wb_pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      reg_write;
    logic [1:0]                last_grant;

    modport slave (
        input  stall, alu_valid, alu_is_link, alu_rd, alu_result, alu_pc_plus4,
               mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, wb_sel, wb_mem_data, wb_alu_result, wb_pc_plus4,
               wb_rd, reg_write, last_grant
    );

    modport master (
        output stall, alu_valid, alu_is_link, alu_rd, alu_result, alu_pc_plus4,
               mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, wb_sel, wb_mem_data, wb_alu_result, wb_pc_plus4,
               wb_rd, reg_write, last_grant
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the register-file write port between ALU/jump and load returns, loads first.
// Define WB_STARVE_GUARD_EN to force an ALU grant after STARVE_LIMIT consecutive blocked ALU cycles.
module wb_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input logic               clk,
    input logic               rst_n,
    wb_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, GRANT_MEM = 2'b01, GRANT_ALU = 2'b10} state_t;

    state_t state, state_nxt;
    logic   starve_force;
    logic   mem_fire;
    logic   alu_fire;

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!bus.alu_valid || alu_fire)
            starve_cnt <= '0;
        else if (!bus.stall && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + CW'(1);
    end

    assign starve_force = (starve_cnt == CW'(STARVE_LIMIT)) && bus.alu_valid && bus.mem_valid;
`else
    // Guard disabled: the limit can never trigger a forced grant.
    assign starve_force = 1'b0 & (STARVE_LIMIT != 0);
`endif

    always_comb begin
        bus.mem_ready = !bus.stall && !starve_force;
        bus.alu_ready = !bus.stall && (!bus.mem_valid || starve_force);
        mem_fire      = bus.mem_valid && bus.mem_ready;
        alu_fire      = bus.alu_valid && bus.alu_ready;
        state_nxt     = mem_fire ? GRANT_MEM : alu_fire ? GRANT_ALU : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign bus.last_grant = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.wb_sel        <= 2'b00;
            bus.wb_mem_data   <= '0;
            bus.wb_alu_result <= '0;
            bus.wb_pc_plus4   <= '0;
            bus.wb_rd         <= '0;
            bus.reg_write     <= 1'b0;
        end else begin
            // x0 grants still update the mux operands but never write the register file
            bus.reg_write <= (mem_fire && |bus.mem_rd) || (alu_fire && |bus.alu_rd);
            if (mem_fire) begin
                bus.wb_sel      <= 2'b00;
                bus.wb_mem_data <= bus.mem_data;
                bus.wb_rd       <= bus.mem_rd;
            end else if (alu_fire) begin
                bus.wb_sel        <= bus.alu_is_link ? 2'b10 : 2'b01;
                bus.wb_alu_result <= bus.alu_result;
                bus.wb_pc_plus4   <= bus.alu_pc_plus4;
                bus.wb_rd         <= bus.alu_rd;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of reset, priority, link select, stall, x0 and starvation handling
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.stall        = 1'b0;
        bus.alu_valid    = 1'b1;
        bus.alu_is_link  = 1'b0;
        bus.alu_rd       = 5'd4;
        bus.alu_result   = 32'h1111;
        bus.alu_pc_plus4 = 32'h2222;
        bus.mem_valid    = 1'b1;
        bus.mem_rd       = 5'd3;
        bus.mem_data     = 32'hAAAA;
        step();
        step();
        chk("rst_wbsel", 32'(bus.wb_sel), 32'h0);
        chk("rst_regwrite", 32'(bus.reg_write), 32'h0);
        chk("rst_wbrd", 32'(bus.wb_rd), 32'h0);
        chk("rst_lastgrant", 32'(bus.last_grant), 32'h0);
        chk("rst_memdata", bus.wb_mem_data, 32'h0);
        chk("rst_aluresult", bus.wb_alu_result, 32'h0);

        rst_n = 1'b1;
        #1;
        chk("rel_memready", 32'(bus.mem_ready), 32'h1);
        chk("rel_aluready", 32'(bus.alu_ready), 32'h0);
        step();
        chk("rel_wbsel", 32'(bus.wb_sel), 32'h0);
        chk("rel_memdata", bus.wb_mem_data, 32'hAAAA);
        chk("rel_wbrd", 32'(bus.wb_rd), 32'h3);
        chk("rel_regwrite", 32'(bus.reg_write), 32'h1);
        chk("rel_lastgrant", 32'(bus.last_grant), 32'h1);

        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        step();
        chk("idle_regwrite", 32'(bus.reg_write), 32'h0);
        chk("idle_lastgrant", 32'(bus.last_grant), 32'h0);
        chk("idle_wbrd_hold", 32'(bus.wb_rd), 32'h3);

        bus.alu_valid    = 1'b1;
        bus.alu_rd       = 5'd5;
        bus.alu_result   = 32'h1234;
        bus.alu_pc_plus4 = 32'h100;
        #1;
        chk("alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        chk("alu_wbsel", 32'(bus.wb_sel), 32'h1);
        chk("alu_result", bus.wb_alu_result, 32'h1234);
        chk("alu_pc4", bus.wb_pc_plus4, 32'h100);
        chk("alu_wbrd", 32'(bus.wb_rd), 32'h5);
        chk("alu_regwrite", 32'(bus.reg_write), 32'h1);
        chk("alu_lastgrant", 32'(bus.last_grant), 32'h2);
        chk("alu_memdata_hold", bus.wb_mem_data, 32'hAAAA);
        bus.alu_valid = 1'b0;
        step();
        chk("alu_pulse_end", 32'(bus.reg_write), 32'h0);

        bus.alu_valid    = 1'b1;
        bus.alu_is_link  = 1'b1;
        bus.alu_rd       = 5'd1;
        bus.alu_result   = 32'h55;
        bus.alu_pc_plus4 = 32'h104;
        step();
        chk("link_wbsel", 32'(bus.wb_sel), 32'h2);
        chk("link_pc4", bus.wb_pc_plus4, 32'h104);
        chk("link_wbrd", 32'(bus.wb_rd), 32'h1);
        chk("link_regwrite", 32'(bus.reg_write), 32'h1);
        bus.alu_is_link = 1'b0;
        bus.alu_rd      = 5'd9;
        bus.alu_result  = 32'h77;
        step();
        chk("b2b_wbsel", 32'(bus.wb_sel), 32'h1);
        chk("b2b_wbrd", 32'(bus.wb_rd), 32'h9);
        chk("b2b_regwrite", 32'(bus.reg_write), 32'h1);

        bus.mem_valid  = 1'b1;
        bus.mem_rd     = 5'd7;
        bus.mem_data   = 32'hDEAD;
        bus.alu_rd     = 5'd2;
        bus.alu_result = 32'h99;
        #1;
        chk("cf_memready", 32'(bus.mem_ready), 32'h1);
        chk("cf_aluready", 32'(bus.alu_ready), 32'h0);
        step();
        chk("cf_wbsel", 32'(bus.wb_sel), 32'h0);
        chk("cf_wbrd", 32'(bus.wb_rd), 32'h7);
        chk("cf_memdata", bus.wb_mem_data, 32'hDEAD);
        chk("cf_alu_hold", bus.wb_alu_result, 32'h77);
        chk("cf_lastgrant", 32'(bus.last_grant), 32'h1);
        bus.mem_valid = 1'b0;
        #1;
        chk("cf2_aluready", 32'(bus.alu_ready), 32'h1);
        step();
        chk("cf2_wbsel", 32'(bus.wb_sel), 32'h1);
        chk("cf2_wbrd", 32'(bus.wb_rd), 32'h2);
        chk("cf2_result", bus.wb_alu_result, 32'h99);
        chk("cf2_lastgrant", 32'(bus.last_grant), 32'h2);

        bus.stall     = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd8;
        bus.mem_data  = 32'hBEEF;
        #1;
        chk("st_memready", 32'(bus.mem_ready), 32'h0);
        chk("st_aluready", 32'(bus.alu_ready), 32'h0);
        step();
        step();
        chk("st_regwrite", 32'(bus.reg_write), 32'h0);
        chk("st_wbsel_hold", 32'(bus.wb_sel), 32'h1);
        chk("st_wbrd_hold", 32'(bus.wb_rd), 32'h2);
        chk("st_memdata_hold", bus.wb_mem_data, 32'hDEAD);
        chk("st_lastgrant", 32'(bus.last_grant), 32'h0);

        bus.stall     = 1'b0;
        bus.alu_valid = 1'b0;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'hF00D;
        step();
        chk("x0_wbsel", 32'(bus.wb_sel), 32'h0);
        chk("x0_wbrd", 32'(bus.wb_rd), 32'h0);
        chk("x0_memdata", bus.wb_mem_data, 32'hF00D);
        chk("x0_regwrite", 32'(bus.reg_write), 32'h0);
        chk("x0_lastgrant", 32'(bus.last_grant), 32'h1);

        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd6;
        bus.mem_rd    = 5'd10;
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef WB_STARVE_GUARD_EN
            chk("sv_aluready", 32'(bus.alu_ready), (i == 4) ? 32'h1 : 32'h0);
            chk("sv_memready", 32'(bus.mem_ready), (i == 4) ? 32'h0 : 32'h1);
`else
            chk("sv_aluready", 32'(bus.alu_ready), 32'h0);
            chk("sv_memready", 32'(bus.mem_ready), 32'h1);
`endif
            step();
        end

        bus.mem_valid = 1'b1;
        bus.alu_valid = 1'b1;
        bus.mem_rd    = 5'd12;
        rst_n         = 1'b0;
        step();
        chk("rst2_regwrite", 32'(bus.reg_write), 32'h0);
        chk("rst2_wbrd", 32'(bus.wb_rd), 32'h0);
        chk("rst2_lastgrant", 32'(bus.last_grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
